// File: rtl/tx_timestamp_sequencer.sv
// tx_timestamp_sequencer
// Queues 64-bit launch-time commands and drives the ENABLE / VALID /
// FR_COUNTER handshake of the pressure stage, so that one TX frame is
// released once COUNTER_TS reaches each commanded time.
// Optional feature: define TX_SEQ_LATE_CNT_EN to count commands whose
// launch time had already passed when they were loaded (LATE_CNT);
// without it LATE_CNT is tied to zero.
module tx_timestamp_sequencer #(
    parameter int FIFO_AW = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [63:0]        CMD_TS,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [63:0]        COUNTER_TS,
    input  logic               FRAME_DONE,
    output logic               ENABLE,
    output logic               VALID,
    output logic [63:0]        FR_COUNTER,
    output logic               BUSY,
    output logic [FIFO_AW:0]   LEVEL,
    output logic [31:0]        LATE_CNT
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DISABLE = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_ARMED   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [63:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [2:0]         state;
    logic [2:0]         next_state;
    logic               frame_done_q;
    logic               push;
    logic               pop;
    logic [63:0]        head;

    assign CMD_READY = (count != FULL_COUNT);
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = (state == S_LOAD);
    assign head      = mem[rd_ptr];
    assign LEVEL     = count;

    // Command storage: written on every accepted push.
    // NOTE: the storage array has no reset; the count and pointers define
    // which entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= CMD_TS;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencing state machine: next-state decode.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (count != '0) next_state = S_DISABLE;
            S_DISABLE: next_state = S_LOAD;
            S_LOAD:    next_state = S_ARMED;
            S_ARMED:   if (COUNTER_TS >= FR_COUNTER) next_state = S_SEND;
            S_SEND:    if (frame_done_q) next_state = S_RELEASE;
            S_RELEASE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // State register and registered handshake outputs decoded from next_state,
    // so each output changes on the same edge as the state it belongs to.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            ENABLE       <= 1'b1;
            VALID        <= 1'b0;
            BUSY         <= 1'b0;
            FR_COUNTER   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= next_state;
            ENABLE       <= !((next_state == S_DISABLE) || (next_state == S_LOAD));
            VALID        <= (next_state == S_ARMED) || (next_state == S_SEND);
            BUSY         <= (next_state != S_IDLE);
            // Only frame-end pulses seen while sending count; others are dropped.
            frame_done_q <= FRAME_DONE && (state == S_SEND);
            if (pop) begin
                FR_COUNTER <= head;
            end
        end
    end

`ifdef TX_SEQ_LATE_CNT_EN
    logic [31:0] late_cnt_q;

    // Saturating count of commands already in the past when loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            late_cnt_q <= '0;
        end else if (pop && (COUNTER_TS > head) && (late_cnt_q != '1)) begin
            late_cnt_q <= late_cnt_q + 32'd1;
        end
    end

    assign LATE_CNT = late_cnt_q;
`else
    assign LATE_CNT = '0;
`endif

endmodule

// File: tb/tb_tx_timestamp_sequencer.sv
// Self-checking bench for tx_timestamp_sequencer. Expected launch times are
// queued when the bench sees a command accepted and compared against
// FR_COUNTER whenever VALID rises. Honors TX_SEQ_LATE_CNT_EN for LATE_CNT.
module tb_tx_timestamp_sequencer;

    logic        clk;
    logic        rst;
    logic [63:0] cmd_ts;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] counter_ts;
    logic        frame_done;
    logic        enable;
    logic        valid;
    logic [63:0] fr_counter;
    logic        busy;
    logic [3:0]  level;
    logic [31:0] late_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ts_run   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [63:0] exp_fr [$];

`ifdef TX_SEQ_LATE_CNT_EN
    localparam logic [31:0] LATE_AFTER_ONE = 32'd1;
`else
    localparam logic [31:0] LATE_AFTER_ONE = 32'd0;
`endif

    tx_timestamp_sequencer #(.FIFO_AW(3)) dut (
        .CLK        (clk),
        .RST        (rst),
        .CMD_TS     (cmd_ts),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .COUNTER_TS (counter_ts),
        .FRAME_DONE (frame_done),
        .ENABLE     (enable),
        .VALID      (valid),
        .FR_COUNTER (fr_counter),
        .BUSY       (busy),
        .LEVEL      (level),
        .LATE_CNT   (late_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

    // One clock: record accepted commands, step the edge, then sample 1 time
    // unit later and score every rising VALID against the queued launch time.
    task automatic tick();
        logic [63:0] exp_v;
        if (cmd_valid && cmd_ready && !rst) exp_fr.push_back(cmd_ts);
        @(posedge clk);
        if (rst) exp_fr.delete();
        #1;
        if (ts_run) counter_ts = counter_ts + 64'd1;
        if (valid === 1'b1 && prev_valid !== 1'b1) begin
            n_checks++;
            if (exp_fr.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_arm: VALID rose with FR_COUNTER=%0d, required no arm", fr_counter);
            end else begin
                exp_v = exp_fr.pop_front();
                if (fr_counter !== exp_v) begin
                    n_fail++;
                    $display("FAIL scoreboard_fr_counter: got %0d, required %0d", fr_counter, exp_v);
                end
            end
        end
        prev_valid = valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL reset_enable: got %b, required 1", enable); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_checks++; if (fr_counter !== 64'd0) begin n_fail++; $display("FAIL reset_fr_counter: got %0d, required 0", fr_counter); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++; if (late_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_late_cnt: got %0d, required 0", late_cnt); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        counter_ts = 64'd1000;
        ts_run     = 1'b1;
        cmd_ts     = 64'd1100;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        n_checks++; if (level !== 4'd1 || enable !== 1'b1) begin n_fail++; $display("FAIL single_push: level=%0d enable=%b, required 1 and 1", level, enable); end
        tick();
        n_checks++; if (enable !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_disable: enable=%b busy=%b, required 0 and 1", enable, busy); end
        tick();
        n_checks++; if (enable !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL single_load: enable=%b valid=%b, required 0 and 0", enable, valid); end
        tick();
        n_checks++; if (enable !== 1'b1 || valid !== 1'b1 || fr_counter !== 64'd1100) begin n_fail++; $display("FAIL single_armed: enable=%b valid=%b fr=%0d, required 1 1 1100", enable, valid, fr_counter); end
        n_checks++; if (level !== 4'd0 || late_cnt !== 32'd0) begin n_fail++; $display("FAIL single_pop: level=%0d late=%0d, required 0 and 0", level, late_cnt); end
        n = 0;
        while (counter_ts != 64'd1100 && n < 200) begin tick(); n++; end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_hold: valid=%b, required 1", valid); end
        // Pulse while still ARMED (COUNTER_TS just reached 1100): must be ignored.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
        tick();
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_early_done: valid=%b, required 1", valid); end
        // Pulse in SEND: VALID drops two cycles later, BUSY one after that.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_done_plus1: valid=%b, required 1", valid); end
        tick();
        n_checks++; if (valid !== 1'b0 || enable !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_release: valid=%b enable=%b busy=%b, required 0 1 1", valid, enable, busy); end
        tick();
        n_checks++; if (busy !== 1'b0 || enable !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b enable=%b valid=%b, required 0 1 0", busy, enable, valid); end
        ts_run = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        counter_ts = 64'd0;
        cmd_ts     = 64'd1000000;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_arm: valid=%b, required 1", valid); end
        for (int i = 0; i < 8; i++) begin
            cmd_ts    = 64'd5000 + 64'(i);
            cmd_valid = 1'b1;
            tick();
        end
        n_checks++; if (level !== 4'd8 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: level=%0d ready=%b, required 8 and 0", level, cmd_ready); end
        cmd_ts = 64'd5008;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (level !== 4'd8 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: level=%0d ready=%b, required 8 and 0", level, cmd_ready); end
        // Let the held frame go so the first queued command is loaded.
        counter_ts = 64'd1000000;
        tick();
        counter_ts = 64'd0;
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        n = 0;
        while (level === 4'd8 && n < 20) begin tick(); n++; end
        n_checks++; if (level !== 4'd7 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_pop: level=%0d ready=%b, required 7 and 1", level, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (level !== 4'd8 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ninth: level=%0d ready=%b, required 8 and 0", level, cmd_ready); end
        n_checks++; if (fr_counter !== 64'd5000 || valid !== 1'b1) begin n_fail++; $display("FAIL b2b_armed_next: fr=%0d valid=%b, required 5000 and 1", fr_counter, valid); end
    endtask

    task automatic test_late();
        do_reset();
        counter_ts = 64'd5000;
        cmd_ts     = 64'd4000;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        tick();
        tick();
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL late_pre_arm: valid=%b, required 0", valid); end
        tick();
        n_checks++; if (valid !== 1'b1 || fr_counter !== 64'd4000) begin n_fail++; $display("FAIL late_armed: valid=%b fr=%0d, required 1 and 4000", valid, fr_counter); end
        n_checks++; if (late_cnt !== LATE_AFTER_ONE) begin n_fail++; $display("FAIL late_cnt: got %0d, required %0d", late_cnt, LATE_AFTER_ONE); end
        tick();
        // Now in SEND after a single ARMED cycle: this pulse must be honored.
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL late_done_plus1: valid=%b, required 1", valid); end
        tick();
        n_checks++; if (valid !== 1'b0 || enable !== 1'b1) begin n_fail++; $display("FAIL late_release: valid=%b enable=%b, required 0 and 1", valid, enable); end
        tick();
        n_checks++; if (busy !== 1'b0 || late_cnt !== LATE_AFTER_ONE) begin n_fail++; $display("FAIL late_idle: busy=%b late=%0d, required 0 and %0d", busy, late_cnt, LATE_AFTER_ONE); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        counter_ts = 64'd0;
        cmd_ts     = 64'd1000000;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < 3; i++) begin
            cmd_ts    = 64'd7000 + 64'(i);
            cmd_valid = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        n_checks++; if (level !== 4'd3 || valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: level=%0d valid=%b, required 3 and 1", level, valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (enable !== 1'b1 || valid !== 1'b0 || level !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: enable=%b valid=%b level=%0d busy=%b, required 1 0 0 0", enable, valid, level, busy); end
        n_checks++; if (fr_counter !== 64'd0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fr: fr=%0d ready=%b, required 0 and 1", fr_counter, cmd_ready); end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (enable !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || level !== 4'd0) begin n_fail++; $display("FAIL rstmid_quiet: enable=%b valid=%b busy=%b level=%0d, required 1 0 0 0", enable, valid, busy, level); end
        end
    endtask

    task automatic test_two_cmds();
        int          n;
        logic [63:0] t;
        bit          saw_idle;
        do_reset();
        counter_ts = 64'd0;
        ts_run     = 1'b1;
        cmd_valid  = 1'b1;
        cmd_ts     = 64'd200;
        tick();
        cmd_ts     = 64'd300;
        tick();
        cmd_valid  = 1'b0;
        for (int f = 0; f < 2; f++) begin
            t = (f == 0) ? 64'd200 : 64'd300;
            n = 0;
            while (valid !== 1'b1 && n < 50) begin tick(); n++; end
            n_checks++; if (valid !== 1'b1 || fr_counter !== t) begin n_fail++; $display("FAIL two_arm%0d: valid=%b fr=%0d, required 1 and %0d", f, valid, fr_counter, t); end
            n = 0;
            while (counter_ts != t + 64'd1 && n < 400) begin tick(); n++; end
            for (int i = 0; i < 5; i++) tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            tick();
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL two_release%0d: valid=%b, required 0", f, valid); end
            tick();
            saw_idle = (enable === 1'b1) && (valid === 1'b0) && (busy === 1'b0);
            n_checks++; if (!saw_idle) begin n_fail++; $display("FAIL two_idle_gap%0d: enable=%b valid=%b busy=%b, required 1 0 0", f, enable, valid, busy); end
        end
        n_checks++; if (level !== 4'd0 || exp_fr.size() != 0) begin n_fail++; $display("FAIL two_drained: level=%0d pending=%0d, required 0 and 0", level, exp_fr.size()); end
        ts_run = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cmd_ts     = 64'd0;
        cmd_valid  = 1'b0;
        counter_ts = 64'd0;
        frame_done = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_late();
        test_reset_mid();
        test_two_cmds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
